// File: rtl/apb_req_master.sv
// APB initiator: one valid/ready request at a time becomes one APB SETUP/ACCESS transfer,
// and its outcome is returned on a held valid/ready response channel.
module apb_req_master #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Counter value seen during the last ACCESS cycle allowed before timing out.
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                    state_q, state_d;
    logic                      req_ready_q, req_ready_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d     = SETUP;
                    req_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    pwrite_d    = req_write_i;
                    paddr_d     = req_addr_i;
                    pwdata_d    = req_wdata_i;
                    cnt_d       = '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // A ready slave always wins over a timeout landing in the same cycle.
                if (pready_i || (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST)) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pready_i ? pslverr_i : 1'b1;
                    rsp_rdata_d = (pready_i && !pwrite_q) ? prdata_i : '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: transaction-level model checked every cycle, plus directed
// scenarios with literal expectations on latency, captured data, errors and reset abort.
module tb_apb_req_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_write_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic [AW-1:0] paddr_o;
    logic [DW-1:0] pwdata_o;
    logic          pwrite_o;
    logic          psel_o;
    logic          penable_o;
    logic [DW-1:0] prdata_i = '0;
    logic          pready_i = 1'b0;
    logic          pslverr_i = 1'b0;

    always #5 clk_i = ~clk_i;

    apb_req_master #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
        .psel_o(psel_o), .penable_o(penable_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: a transfer is "active" from acceptance until its response is consumed;
    // age counts cycles since acceptance, stall counts ACCESS cycles without pready.
    logic          m_active, m_rsp, m_err, m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    int            m_age, m_stall;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_active <= 1'b0; m_rsp <= 1'b0; m_err <= 1'b0; m_write <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_age <= 0; m_stall <= 0;
        end else if (!m_active) begin
            if (req_valid_i) begin
                m_active <= 1'b1; m_age <= 1; m_stall <= 0;
                m_addr <= req_addr_i; m_wdata <= req_wdata_i; m_write <= req_write_i;
            end
        end else if (!m_rsp) begin
            if (m_age == 1) begin
                m_age <= 2;
            end else if (pready_i) begin
                m_rsp <= 1'b1; m_err <= pslverr_i; m_rdata <= m_write ? '0 : prdata_i;
            end else if (m_stall + 1 == TO) begin
                m_rsp <= 1'b1; m_err <= 1'b1; m_rdata <= '0;
            end else begin
                m_stall <= m_stall + 1;
            end
        end else if (rsp_ready_i) begin
            m_active <= 1'b0; m_rsp <= 1'b0;
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            check("req_ready", 64'(req_ready_o), 64'(!m_active));
            check("psel", 64'(psel_o), 64'(m_active && !m_rsp));
            check("penable", 64'(penable_o), 64'(m_active && !m_rsp && m_age >= 2));
            check("rsp_valid", 64'(rsp_valid_o), 64'(m_rsp));
            check("paddr", 64'(paddr_o), 64'(m_addr));
            check("pwdata", 64'(pwdata_o), 64'(m_wdata));
            check("pwrite", 64'(pwrite_o), 64'(m_write));
            if (m_rsp) begin
                check("rsp_rdata", 64'(rsp_rdata_o), 64'(m_rdata));
                check("rsp_err", 64'(rsp_err_o), 64'(m_err));
            end
        end
    end

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int stalls, input logic serr, input logic [DW-1:0] prd,
                        input int rdelay, output logic got_err, output logic [DW-1:0] got_rd,
                        output int lat, output int acc, output int hold);
        int n;
        int k;
        int d;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_wdata_i = wdata;
        n = 0;
        while (!req_ready_o && n < 50) begin @(negedge clk_i); n++; end
        if (n >= 50) bound_fail("accept_bound");
        @(negedge clk_i);
        req_valid_i = 1'b0;
        lat = 1; acc = 0; k = 0; n = 0;
        while (!rsp_valid_o && n < 100) begin
            prdata_i = prd; pslverr_i = serr;
            if (penable_o) begin acc++; pready_i = (k == stalls); k++; end
            else pready_i = 1'b0;
            @(negedge clk_i); lat++; n++;
        end
        pready_i = 1'b0; pslverr_i = 1'b0;
        if (n >= 100) bound_fail("rsp_bound");
        got_err = rsp_err_o; got_rd = rsp_rdata_o;
        d = 0; n = 0; hold = 0;
        while (rsp_valid_o && n < 100) begin
            check("hold_rdata", 64'(rsp_rdata_o), 64'(got_rd));
            check("hold_err", 64'(rsp_err_o), 64'(got_err));
            check("hold_req_ready", 64'(req_ready_o), 64'(0));
            rsp_ready_i = (d >= rdelay); d++; hold++;
            @(negedge clk_i); n++;
        end
        rsp_ready_i = 1'b0;
        if (n >= 100) bound_fail("handshake_bound");
    endtask

    logic          e;
    logic [DW-1:0] rd;
    int            lat, acc, hold, n;

    initial begin
        #1 rst_ni = 1'b0;
        #2;
        check("rst_req_ready", 64'(req_ready_o), 64'(1));
        check("rst_psel", 64'(psel_o), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("rst_paddr", 64'(paddr_o), 64'(0));
        @(posedge clk_i); @(posedge clk_i); #2 rst_ni = 1'b1;

        // 1: write, immediate pready
        xfer(1'b1, 32'h1A10_0004, 32'hDEAD_BEEF, 0, 1'b0, 32'h5555_AAAA, 0, e, rd, lat, acc, hold);
        check("t1_latency", 64'(lat), 64'(3));
        check("t1_err", 64'(e), 64'(0));
        check("t1_rdata", 64'(rd), 64'(0));
        check("t1_access", 64'(acc), 64'(1));
        check("t1_paddr_kept", 64'(paddr_o), 64'(32'h1A10_0004));
        check("t1_pwdata_kept", 64'(pwdata_o), 64'(32'hDEAD_BEEF));

        // 2: read with 3 wait states
        xfer(1'b0, 32'h1A10_0008, 32'h0, 3, 1'b0, 32'h1234_5678, 0, e, rd, lat, acc, hold);
        check("t2_rdata", 64'(rd), 64'(32'h1234_5678));
        check("t2_err", 64'(e), 64'(0));
        check("t2_access", 64'(acc), 64'(4));
        check("t2_latency", 64'(lat), 64'(6));

        // 3: slave error
        xfer(1'b0, 32'h1A10_000C, 32'h0, 0, 1'b1, 32'hCAFE_F00D, 0, e, rd, lat, acc, hold);
        check("t3_err", 64'(e), 64'(1));
        check("t3_rdata", 64'(rd), 64'(32'hCAFE_F00D));

        // 4a: pready never arrives
        xfer(1'b0, 32'h0000_0010, 32'h0, 1000, 1'b0, 32'h7777_7777, 0, e, rd, lat, acc, hold);
        check("t4a_err", 64'(e), 64'(1));
        check("t4a_rdata", 64'(rd), 64'(0));
        check("t4a_access", 64'(acc), 64'(4));

        // 4b: pready on the 4th ACCESS cycle beats the timeout
        xfer(1'b0, 32'h0000_0014, 32'h0, 3, 1'b0, 32'h0BAD_C0DE, 0, e, rd, lat, acc, hold);
        check("t4b_err", 64'(e), 64'(0));
        check("t4b_rdata", 64'(rd), 64'(32'h0BAD_C0DE));

        // 5: consumer stalls 5 cycles
        xfer(1'b0, 32'h0000_0018, 32'h0, 0, 1'b0, 32'h1111_2222, 5, e, rd, lat, acc, hold);
        check("t5_hold_cycles", 64'(hold), 64'(6));
        check("t5_rdata", 64'(rd), 64'(32'h1111_2222));

        // 6: reset during ACCESS
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h0000_0020;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        n = 0;
        while (!penable_o && n < 20) begin @(negedge clk_i); n++; end
        if (n >= 20) bound_fail("t6_access_bound");
        #2 rst_ni = 1'b0;
        #1;
        check("t6_psel_drop", 64'(psel_o), 64'(0));
        check("t6_penable_drop", 64'(penable_o), 64'(0));
        check("t6_rsp_valid", 64'(rsp_valid_o), 64'(0));
        @(posedge clk_i); @(posedge clk_i); #2 rst_ni = 1'b1;
        @(negedge clk_i);
        check("t6_req_ready", 64'(req_ready_o), 64'(1));
        check("t6_no_rsp", 64'(rsp_valid_o), 64'(0));
        xfer(1'b1, 32'h0000_0024, 32'hA5A5_5A5A, 1, 1'b0, 32'h0, 0, e, rd, lat, acc, hold);
        check("t6_next_err", 64'(e), 64'(0));
        check("t6_next_latency", 64'(lat), 64'(4));

        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
